tick_generator: RTL and testbench

TICK_GENERATOR -- requirements
Module: tick_generator

---
 rtl/tick_generator.sv | 123 ++++++++++++
 tb/tb_tick_generator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_generator.sv
// Multi-channel programmable tick generator: each channel divides clk by its own
// divisor, emitting a one-cycle tick and a square wave; divisors load via a 2-state config port.
module tick_generator #(
  parameter int unsigned     BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int unsigned     NUM_CHANNELS                = 4,
  parameter int unsigned     DIV_WIDTH                   = 32,
  parameter longint unsigned DEFAULT_DIVISOR             = BOARD_CLOCK_FREQUENCY_IN_HZ,
  localparam int unsigned    CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CHANNELS-1:0] enable,
  input  logic [NUM_CHANNELS-1:0] clear,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_W-1:0]         cfg_channel,
  input  logic [DIV_WIDTH-1:0]    cfg_divisor,
  output logic                    cfg_err,
  output logic [NUM_CHANNELS-1:0] tick,
  output logic [NUM_CHANNELS-1:0] clk_out
);

  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIVISOR);

  // Reject illegal configurations at elaboration time.
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16) begin : g_bad_channels
    $error("tick_generator: NUM_CHANNELS must be in 1..16");
  end
  if (DEFAULT_DIVISOR == 0 || (DEFAULT_DIVISOR >> DIV_WIDTH) != 0) begin : g_bad_default
    $error("tick_generator: DEFAULT_DIVISOR must be nonzero and fit DIV_WIDTH");
  end

  typedef enum logic {IDLE, APPLY} state_t;

  typedef struct packed {
    logic [CH_W-1:0]      channel;
    logic [DIV_WIDTH-1:0] divisor;
  } cfg_req_t;

  state_t   state;
  cfg_req_t req;
  logic     ch_ok;
  logic     req_ok;

  // Channel indices beyond NUM_CHANNELS only exist when it is not a power of two.
  if ((1 << CH_W) == NUM_CHANNELS) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (32'(req.channel) < NUM_CHANNELS);
  end

  assign req_ok = ch_ok && (req.divisor != '0);

  // Config FSM: accept in IDLE, apply (or reject) on the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req       <= '0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            req.channel <= cfg_channel;
            req.divisor <= cfg_divisor;
            state       <= APPLY;
            cfg_ready   <= 1'b0;
          end
        end
        APPLY: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
          cfg_err   <= !req_ok;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_inc;
    logic                 wrap;
    logic                 load;
    logic                 tick_q;
    logic                 clk_q;

    assign load    = (state == APPLY) && req_ok && (req.channel == CH_W'(g));
    assign wrap    = (cnt_q >= div_q - DIV_WIDTH'(1));
    assign cnt_inc = wrap ? '0 : cnt_q + DIV_WIDTH'(1);

    // A divisor load beats clear, which beats enable.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        div_q  <= DEF_DIV;
        cnt_q  <= '0;
        tick_q <= 1'b0;
        clk_q  <= 1'b0;
      end else if (load) begin
        div_q  <= req.divisor;
        cnt_q  <= '0;
        tick_q <= 1'b0;
        clk_q  <= 1'b0;
      end else if (clear[g]) begin
        cnt_q  <= '0;
        tick_q <= 1'b0;
        clk_q  <= 1'b0;
      end else if (enable[g]) begin
        cnt_q  <= cnt_inc;
        tick_q <= wrap;
        clk_q  <= (cnt_inc >= (div_q >> 1));
      end else begin
        tick_q <= 1'b0;
      end
    end

    assign tick[g]    = tick_q;
    assign clk_out[g] = clk_q;
  end

endmodule

// File: tb/tb_tick_generator.sv
// Directed scoreboard bench for tick_generator: 2-channel main instance plus a
// 3-channel instance for out-of-range channel writes.
module tb_tick_generator;

  localparam int unsigned NCH = 2;
  localparam int unsigned DW  = 8;
  localparam int unsigned DEF = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] enable, clear, tick, clk_out;
  logic           cfg_valid, cfg_ready, cfg_err;
  logic [0:0]     cfg_channel;
  logic [DW-1:0]  cfg_divisor;

  logic [2:0]     enable3, clear3, tick3, clk_out3;
  logic           cfg_valid3, cfg_ready3, cfg_err3;
  logic [1:0]     cfg_channel3;
  logic [DW-1:0]  cfg_divisor3;

  tick_generator #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ(DEF), .NUM_CHANNELS(NCH), .DIV_WIDTH(DW), .DEFAULT_DIVISOR(DEF)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_channel(cfg_channel),
    .cfg_divisor(cfg_divisor), .cfg_err(cfg_err), .tick(tick), .clk_out(clk_out)
  );

  tick_generator #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ(DEF), .NUM_CHANNELS(3), .DIV_WIDTH(DW), .DEFAULT_DIVISOR(DEF)
  ) dut3 (
    .clk(clk), .rst(rst), .enable(enable3), .clear(clear3),
    .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3), .cfg_channel(cfg_channel3),
    .cfg_divisor(cfg_divisor3), .cfg_err(cfg_err3), .tick(tick3), .clk_out(clk_out3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk_out;
    logic           err;
    logic           ready;
  } exp_t;

  exp_t           sb[$];
  int             checks = 0;
  int             errors = 0;
  int             per[NCH];
  int             n[NCH];
  logic [NCH-1:0] co_m;
  logic           busy;
  int             lat_ch, lat_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      per[i] = DEF;
      n[i]   = 0;
    end
    co_m = '0;
    busy = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".tick"}, 32'(tick), 32'd0);
    chk({tag, ".clk_out"}, 32'(clk_out), 32'd0);
    chk({tag, ".cfg_err"}, 32'(cfg_err), 32'd0);
    chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'd1);
  endtask

  // Expected period behaviour: n counts enabled edges since the last restart.
  task automatic step(input string tag, input logic [NCH-1:0] en, input logic [NCH-1:0] clr,
                      input logic cv, input int ch, input int dv);
    exp_t e;
    logic apply, legal;
    enable = en; clear = clr; cfg_valid = cv; cfg_channel = 1'(ch); cfg_divisor = DW'(dv);
    apply = busy;
    legal = apply && (lat_d != 0) && (lat_ch < NCH);
    e.tick = '0;
    for (int i = 0; i < NCH; i++) begin
      if (legal && lat_ch == i) begin
        per[i] = lat_d; n[i] = 0; co_m[i] = 1'b0;
      end else if (clr[i]) begin
        n[i] = 0; co_m[i] = 1'b0;
      end else if (en[i]) begin
        n[i]++;
        e.tick[i] = ((n[i] % per[i]) == 0);
        co_m[i]   = ((n[i] % per[i]) >= per[i] / 2);
      end
    end
    if (apply) busy = 1'b0;
    else if (cv) begin
      busy = 1'b1; lat_ch = ch; lat_d = dv;
    end
    e.clk_out = co_m;
    e.err     = apply && !legal;
    e.ready   = !busy;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, ".tick"}, 32'(tick), 32'(e.tick));
    chk({tag, ".clk_out"}, 32'(clk_out), 32'(e.clk_out));
    chk({tag, ".cfg_err"}, 32'(cfg_err), 32'(e.err));
    chk({tag, ".cfg_ready"}, 32'(cfg_ready), 32'(e.ready));
  endtask

  task automatic run(input string tag, input logic [NCH-1:0] en, input int cycles);
    for (int k = 0; k < cycles; k++) step(tag, en, '0, 1'b0, 0, 0);
  endtask

  task automatic wr(input string tag, input logic [NCH-1:0] en, input int ch, input int dv,
                    input logic [NCH-1:0] clr_apply);
    step({tag, ".acc"}, en, '0, 1'b1, ch, dv);
    step({tag, ".app"}, en, clr_apply, 1'b0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    enable = '0; clear = '0; cfg_valid = 1'b0; cfg_channel = '0; cfg_divisor = '0;
    enable3 = '0; clear3 = '0; cfg_valid3 = 1'b0; cfg_channel3 = '0; cfg_divisor3 = '0;
    lat_ch = 0; lat_d = 0;
    model_reset();

    // Held in reset across clock edges
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b1;

    // Default divisor 5 on ch0 only
    run("def5", 2'b01, 15);

    // ch1 gets D=3, ch0 keeps its phase
    wr("wr_d3", 2'b01, 1, 3, 2'b00);
    run("d3", 2'b11, 9);

    // Zero divisor rejected, nothing changes
    wr("wr_d0", 2'b11, 0, 0, 2'b00);
    run("after_d0", 2'b11, 6);

    // D=4 on ch0, pause at cnt=2, resume, then clear mid-run
    wr("wr_d4", 2'b11, 0, 4, 2'b00);
    run("d4_run", 2'b11, 2);
    run("d4_hold", 2'b10, 3);
    run("d4_resume", 2'b11, 4);
    step("d4_clear", 2'b11, 2'b01, 1'b0, 0, 0);
    run("d4_after_clr", 2'b11, 5);

    // Line the apply edge up with a ch0 wrap: the load must suppress that tick
    for (int k = 0; k < 8 && ((n[0] + 2) % per[0]) != 0; k++) step("align", 2'b11, '0, 1'b0, 0, 0);
    wr("wr_on_wrap", 2'b11, 0, 3, 2'b00);
    run("after_wrap", 2'b11, 4);

    // Clear on the apply edge still loads the divisor
    wr("wr_clr", 2'b11, 1, 2, 2'b10);
    run("d2", 2'b11, 4);

    // D=1: tick and clk_out stay high while enabled
    wr("wr_d1", 2'b11, 1, 1, 2'b00);
    run("d1", 2'b11, 3);

    // Asynchronous reset mid-cycle, mid-count
    #2;
    rst = 1'b0;
    #1;
    chk_reset("async_rst");
    @(posedge clk); #1;
    chk_reset("rst_held");
    rst = 1'b1;
    model_reset();
    run("post_rst", 2'b11, 6);

    // Out-of-range channel on the 3-channel instance
    cfg_valid3 = 1'b1; cfg_channel3 = 2'd3; cfg_divisor3 = 8'd2;
    @(posedge clk); #1;
    cfg_valid3 = 1'b0;
    chk("ch3.ready_acc", 32'(cfg_ready3), 32'd0);
    chk("ch3.err_acc", 32'(cfg_err3), 32'd0);
    @(posedge clk); #1;
    chk("ch3.ready_app", 32'(cfg_ready3), 32'd1);
    chk("ch3.err_app", 32'(cfg_err3), 32'd1);
    enable3 = 3'b111;
    @(posedge clk); #1;
    chk("ch3.err_drop", 32'(cfg_err3), 32'd0);
    chk("ch3.tick1", 32'(tick3), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      @(posedge clk); #1;
      chk("ch3.tick", 32'(tick3), (k == 5) ? 32'h7 : 32'h0);
      chk("ch3.clk_out", 32'(clk_out3), (k >= 2 && k <= 4) ? 32'h7 : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
